// File: rtl/conv_mem_mac_if.sv
// conv_mem_mac_if: conv_ctrl strobe/address bus, host port and status.
// master = controller/host side, slave = conv_mem_mac.
interface conv_mem_mac_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 8
);
  logic              en_read;
  logic              en_mac;
  logic              en_sum;
  logic              en_save;
  logic              en_write;
  logic              finish;
  logic [ADDR_W-1:0] s_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] save_addr;
  logic              host_we;
  logic [1:0]        host_sel;
  logic [MEM_AW-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;
  logic              sat_flag;
  logic [ADDR_W-1:0] wr_count;

  modport master (
    output en_read, en_mac, en_sum, en_save, en_write, finish,
    output s_addr, w_addr, b_addr, save_addr,
    output host_we, host_sel, host_addr, host_wdata,
    input  host_rdata, result, busy, done, sat_flag, wr_count
  );

  modport slave (
    input  en_read, en_mac, en_sum, en_save, en_write, finish,
    input  s_addr, w_addr, b_addr, save_addr,
    input  host_we, host_sel, host_addr, host_wdata,
    output host_rdata, result, busy, done, sat_flag, wr_count
  );
endinterface

// File: rtl/conv_mem_mac.sv
// conv_mem_mac: operand/output memories + MAC/bias/round/saturate datapath.
// Ports: clk, reset (async active-low), bus (conv_mem_mac_if.slave).
module conv_mem_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 8
) (
  input logic           clk,
  input logic           reset,
  conv_mem_mac_if.slave bus
);
  localparam int DEPTH = 2**MEM_AW;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2**(FRAC_W-1));
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_W-1)-1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic [1:0]               r_state;
  logic [DATA_W-1:0]        r_smem [DEPTH];
  logic [DATA_W-1:0]        r_wmem [DEPTH];
  logic [DATA_W-1:0]        r_bmem [DEPTH];
  logic [DATA_W-1:0]        r_omem [DEPTH];
  logic signed [DATA_W-1:0] r_s_op;
  logic signed [DATA_W-1:0] r_w_op;
  logic signed [DATA_W-1:0] r_b_op;
  logic signed [DATA_W-1:0] r_result;
  logic [DATA_W-1:0]        r_rdata;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_sat;
  logic [ADDR_W-1:0]        r_wr_cnt;

  logic [MEM_AW-1:0] w_sa, w_wa, w_ba, w_oa;
  logic              w_unused;
  assign w_sa = bus.s_addr[MEM_AW-1:0];
  assign w_wa = bus.w_addr[MEM_AW-1:0];
  assign w_ba = bus.b_addr[MEM_AW-1:0];
  assign w_oa = bus.save_addr[MEM_AW-1:0];
  assign w_unused = ^{bus.s_addr[ADDR_W-1:MEM_AW],
                      bus.w_addr[ADDR_W-1:MEM_AW],
                      bus.b_addr[ADDR_W-1:MEM_AW],
                      bus.save_addr[ADDR_W-1:MEM_AW]};

  logic w_busy, w_act, w_start;
  logic w_mac_en, w_sum_en, w_save_en, w_wr_en, w_host_wr;
  assign w_busy    = (r_state == S_RUN);
  assign w_act     = (r_state != S_IDLE);
  assign w_start   = (r_state == S_IDLE) && bus.en_read && !bus.finish;
  assign w_mac_en  = w_act && bus.en_mac;
  assign w_sum_en  = w_act && bus.en_sum;
  assign w_save_en = w_act && bus.en_save;
  assign w_wr_en   = w_act && bus.en_write;
  assign w_host_wr = bus.host_we && !w_busy;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_mac, w_sum, w_base, w_acc_nxt;
  assign w_prod = r_s_op * r_w_op;
  assign w_mac  = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_sum  = {{(ACC_W-DATA_W-FRAC_W){r_b_op[DATA_W-1]}},
                   r_b_op, {FRAC_W{1'b0}}};
  // save sees the pre-update acc; same-cycle mac/sum start the next window
  assign w_base    = w_save_en ? '0 : r_acc;
  assign w_acc_nxt = w_base + (w_mac_en ? w_mac : '0)
                            + (w_sum_en ? w_sum : '0);

  // one guard bit so the rounding add cannot wrap
  logic signed [ACC_W:0]    w_rnd, w_t;
  logic signed [DATA_W-1:0] w_clamp, w_res_nxt;
  logic                     w_ovf;
  assign w_rnd = $signed({r_acc[ACC_W-1], r_acc}) + RND;
  assign w_t   = w_rnd >>> FRAC_W;

  always_comb begin
    w_ovf   = 1'b0;
    w_clamp = w_t[DATA_W-1:0];
    if (w_t > MAXV) begin
      w_ovf   = 1'b1;
      w_clamp = MAXV[DATA_W-1:0];
    end else if (w_t < MINV) begin
      w_ovf   = 1'b1;
      w_clamp = MINV[DATA_W-1:0];
    end
  end

  // en_write stores the value produced by a same-cycle en_save
  assign w_res_nxt = w_save_en ? w_clamp : r_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_s_op   <= '0;
      r_w_op   <= '0;
      r_b_op   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
      r_wr_cnt <= '0;
      r_rdata  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:  if (bus.finish) r_state <= S_DONE;
                 else if (bus.en_read) r_state <= S_RUN;
        S_RUN:   if (bus.finish) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      if (bus.en_read) begin
        r_s_op <= r_smem[w_sa];
        r_w_op <= r_wmem[w_wa];
        r_b_op <= r_bmem[w_ba];
      end
      r_acc    <= w_act ? w_acc_nxt : r_acc;
      r_result <= w_res_nxt;
      if (w_start)
        r_sat <= 1'b0;
      else if (w_save_en && w_ovf)
        r_sat <= 1'b1;
      if (w_start)
        r_wr_cnt <= '0;
      else if (w_wr_en)
        r_wr_cnt <= r_wr_cnt + 1'b1;
      case (bus.host_sel)
        2'd0:    r_rdata <= r_smem[bus.host_addr];
        2'd1:    r_rdata <= r_wmem[bus.host_addr];
        2'd2:    r_rdata <= r_bmem[bus.host_addr];
        default: r_rdata <= r_omem[bus.host_addr];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_host_wr && bus.host_sel == 2'd0)
      r_smem[bus.host_addr] <= bus.host_wdata;
    if (w_host_wr && bus.host_sel == 2'd1)
      r_wmem[bus.host_addr] <= bus.host_wdata;
    if (w_host_wr && bus.host_sel == 2'd2)
      r_bmem[bus.host_addr] <= bus.host_wdata;
    if (w_wr_en)
      r_omem[w_oa] <= w_res_nxt;
    else if (w_host_wr && bus.host_sel == 2'd3)
      r_omem[bus.host_addr] <= bus.host_wdata;
  end

  assign bus.result     = r_result;
  assign bus.host_rdata = r_rdata;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.sat_flag   = r_sat;
  assign bus.wr_count   = r_wr_cnt;
endmodule

// File: tb/tb_conv_mem_mac.sv
// tb_conv_mem_mac: directed bench for conv_mem_mac.
// Linear stimulus, immediate assertions at each check.
module tb_conv_mem_mac;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  conv_mem_mac_if #(.DATA_W(16), .ADDR_W(16), .MEM_AW(8)) bus ();

  conv_mem_mac #(
    .DATA_W(16), .ACC_W(40), .FRAC_W(8), .ADDR_W(16), .MEM_AW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.en_read  = 1'b0;
    bus.en_mac   = 1'b0;
    bus.en_sum   = 1'b0;
    bus.en_save  = 1'b0;
    bus.en_write = 1'b0;
    bus.finish   = 1'b0;
    bus.host_we  = 1'b0;
  endtask

  task automatic hw(input logic [1:0] sel, input logic [7:0] a,
                    input logic [15:0] d);
    bus.host_we    = 1'b1;
    bus.host_sel   = sel;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
  endtask

  task automatic hrd(input logic [1:0] sel, input logic [7:0] a);
    bus.host_sel  = sel;
    bus.host_addr = a;
    tick();
  endtask

  task automatic rdop(input logic [15:0] s, input logic [15:0] w,
                      input logic [15:0] b);
    bus.en_read = 1'b1;
    bus.s_addr  = s;
    bus.w_addr  = w;
    bus.b_addr  = b;
  endtask

  initial begin
    bus.en_read = 1'b0; bus.en_mac = 1'b0; bus.en_sum = 1'b0;
    bus.en_save = 1'b0; bus.en_write = 1'b0; bus.finish = 1'b0;
    bus.s_addr = '0; bus.w_addr = '0; bus.b_addr = '0;
    bus.save_addr = '0; bus.host_we = 1'b0; bus.host_sel = 2'd0;
    bus.host_addr = '0; bus.host_wdata = '0;

    tick();
    tick();
    chk("rst_result", $signed(bus.result), 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sat", bus.sat_flag, 0);
    chk("rst_wrcnt", bus.wr_count, 0);
    chk("rst_rdata", bus.host_rdata, 0);
    reset = 1'b1;
    tick();

    hw(2'd0, 8'd0, 16'd256);
    hw(2'd0, 8'd1, 16'd512);
    hw(2'd1, 8'd0, 16'd256);
    hw(2'd1, 8'd1, 16'd256);
    hw(2'd2, 8'd0, 16'd128);
    hw(2'd0, 8'd2, 16'd32767);
    hw(2'd1, 8'd2, 16'd32767);
    hw(2'd1, 8'd3, 16'h8000);
    hw(2'd0, 8'd4, 16'd768);
    hw(2'd1, 8'd4, 16'd512);
    hw(2'd0, 8'd5, 16'd256);
    hw(2'd1, 8'd5, 16'd256);
    hw(2'd0, 8'd3, 16'd1280);
    hw(2'd1, 8'd6, 16'd256);
    hw(2'd0, 8'd10, 16'h0AAA);

    // 1.0*1.0 + 2.0*1.0 + 0.5 -> 3.5
    rdop(16'd0, 16'd0, 16'd0); tick();
    chk("t1_busy", bus.busy, 1);
    rdop(16'd1, 16'd1, 16'd0); bus.en_mac = 1'b1; tick();
    bus.en_mac = 1'b1; tick();
    bus.en_sum = 1'b1; tick();
    bus.en_save = 1'b1; tick();
    chk("t1_result", $signed(bus.result), 896);
    bus.en_write = 1'b1; bus.save_addr = 16'd5; tick();
    chk("t1_wrcnt", bus.wr_count, 1);
    bus.finish = 1'b1; tick();
    chk("t5_busy_fall", bus.busy, 0);
    chk("t5_done_hi", bus.done, 1);
    tick();
    chk("t5_done_lo", bus.done, 0);
    hrd(2'd3, 8'd5);
    chk("t1_omem5", bus.host_rdata, 896);

    // saturation both ways
    rdop(16'd2, 16'd2, 16'd0); tick();
    chk("t2_sat_clr", bus.sat_flag, 0);
    chk("t2_wrcnt_clr", bus.wr_count, 0);
    repeat (4) begin bus.en_mac = 1'b1; tick(); end
    bus.en_save = 1'b1; tick();
    chk("t2_pos_sat", $signed(bus.result), 32767);
    chk("t2_sat_flag", bus.sat_flag, 1);
    rdop(16'd2, 16'd3, 16'd0); tick();
    bus.en_mac = 1'b1; tick();
    bus.en_save = 1'b1; tick();
    chk("t2_neg_sat", $signed(bus.result), -32768);

    // host write dropped while busy
    hw(2'd0, 8'd10, 16'h1234);
    chk("t4_busy", bus.busy, 1);
    bus.finish = 1'b1; tick();
    tick();
    hrd(2'd0, 8'd10);
    chk("t4_dropped", bus.host_rdata, 16'h0AAA);
    hw(2'd0, 8'd10, 16'h1234);
    chk("t4_rbw_old", bus.host_rdata, 16'h0AAA);
    hrd(2'd0, 8'd10);
    chk("t4_written", bus.host_rdata, 16'h1234);

    // save + mac same cycle, save + write forwarded, wrapped save_addr
    rdop(16'd4, 16'd4, 16'd0); tick();
    chk("t3_sat_clr", bus.sat_flag, 0);
    rdop(16'd5, 16'd5, 16'd0); bus.en_mac = 1'b1; tick();
    bus.en_save = 1'b1; bus.en_mac = 1'b1; tick();
    chk("t3_old_acc", $signed(bus.result), 1536);
    bus.en_save = 1'b1; bus.en_write = 1'b1;
    bus.save_addr = 16'h0107; tick();
    chk("t3_new_prod", $signed(bus.result), 256);
    chk("t3_wrcnt", bus.wr_count, 1);
    bus.finish = 1'b1; tick();
    tick();
    hrd(2'd3, 8'd7);
    chk("t3_fwd_omem7", bus.host_rdata, 256);

    // upper address bits ignored
    rdop(16'h0103, 16'h0206, 16'h0300); tick();
    bus.en_mac = 1'b1; tick();
    bus.en_save = 1'b1; tick();
    chk("t6_wrap", $signed(bus.result), 1280);

    // async reset mid-layer
    bus.en_mac = 1'b1; tick();
    reset = 1'b0;
    #2;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_done", bus.done, 0);
    chk("t5_rst_result", $signed(bus.result), 0);
    chk("t5_rst_rdata", bus.host_rdata, 0);
    chk("t5_rst_wrcnt", bus.wr_count, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_no_done", bus.done, 0);

    // finish while idle still pulses done
    bus.finish = 1'b1; tick();
    chk("t5_idle_done", bus.done, 1);
    chk("t5_idle_busy", bus.busy, 0);
    tick();
    chk("t5_idle_done_lo", bus.done, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
